// File: rtl/legv8_multicycle_control_if.sv
// Control bundle between the multicycle LEGv8 main control FSM and the
// datapath / memory side.
//
// Signals:
//   opcode     IR[31:21], supplied by the datapath, stable from DECODE onward
//   mem_ready  memory finishes the current read/write this cycle
//   ALUOp      00 add, 01 pass B (CBZ), 10 decode from opcode
//   alu_src_a  0 PC, 1 register A
//   alu_src_b  00 reg B, 01 constant 4, 10 sign-extended imm, 11 branch offset <<2
//   reg2loc    1 selects Rt as read register 2
//   i_or_d     0 PC address, 1 ALUOut address
//   mem_read / mem_write / ir_write / pc_write / pc_write_cond / reg_write
//   pc_source  00 ALU result, 01 ALUOut, 10 reserved
//   mem_to_reg 1 writeback from MDR
//   illegal    sticky unsupported-opcode flag
//   state      current FSM state, for debug
//
// Modports: master = control FSM (drives the control outputs),
//           slave  = datapath (drives opcode and mem_ready).
//
// Handshake: there is no valid/ready pair on this bundle. mem_ready is a
// completion qualifier: a memory access requested by mem_read/mem_write is
// considered done in the cycle where mem_ready=1, and the FSM holds its
// request steady until that cycle.
interface legv8_multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [10:0]        opcode;
  logic               mem_ready;
  logic [1:0]         ALUOp;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic               reg2loc;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               pc_write;
  logic               pc_write_cond;
  logic [1:0]         pc_source;
  logic               mem_to_reg;
  logic               reg_write;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, mem_ready,
    output ALUOp, alu_src_a, alu_src_b, reg2loc, i_or_d, mem_read, mem_write,
           ir_write, pc_write, pc_write_cond, pc_source, mem_to_reg, reg_write,
           illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  ALUOp, alu_src_a, alu_src_b, reg2loc, i_or_d, mem_read, mem_write,
           ir_write, pc_write, pc_write_cond, pc_source, mem_to_reg, reg_write,
           illegal, state
  );
endinterface

// File: rtl/legv8_multicycle_control.sv
// Main control FSM for the multicycle LEGv8 datapath.
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback states and produces datapath enables, mux selects and the 2-bit
// ALUOp consumed by the ALU control decoder.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  legv8_multicycle_control_if.master (opcode/mem_ready in, controls out)
//
// Outputs are Moore-decoded from the state register, except ir_write and
// pc_write in FETCH, which follow mem_ready. All write strobes are forced
// low while rst is high so an abandoned instruction never writes anything
// in the reset cycle.
module legv8_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  legv8_multicycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BR_CBZ   = 4'd9,
    S_BR_B     = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   illegal_q;

  // Opcode classification
  logic is_r_type;
  logic is_i_type;
  logic is_ldur;
  logic is_stur;
  logic is_cbz;
  logic is_b;

  always_comb begin
    is_r_type = (bus.opcode == 11'h458) || (bus.opcode == 11'h658) ||
                (bus.opcode == 11'h450) || (bus.opcode == 11'h550) ||
                (bus.opcode == 11'h69B) || (bus.opcode == 11'h69A);
    // Immediate forms carry one bit of the immediate in the opcode LSB.
    is_i_type = (bus.opcode[10:1] == 10'h244) ||   // ADDI 0x488-0x489
                (bus.opcode[10:1] == 10'h344) ||   // SUBI 0x688-0x689
                (bus.opcode[10:1] == 10'h248) ||   // ANDI 0x490-0x491
                (bus.opcode[10:1] == 10'h2C8);     // ORRI 0x590-0x591
    is_ldur   = (bus.opcode == 11'h7C2);
    is_stur   = (bus.opcode == 11'h7C0);
    is_cbz    = (bus.opcode[10:3] == 8'hB4);       // 0x5A0-0x5A7
    is_b      = (bus.opcode[10:5] == 6'h05);       // 0x0A0-0x0BF
  end

  // State register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_ILLEGAL) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Raw (ungated) control values
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg2loc;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       pc_write_raw;
  logic       pc_write_cond_raw;
  logic [1:0] pc_source;
  logic       mem_to_reg;
  logic       reg_write_raw;

  // Next-state and output decode
  always_comb begin
    state_d           = state_q;
    alu_op            = 2'b00;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    reg2loc           = 1'b0;
    i_or_d            = 1'b0;
    mem_read          = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    pc_source         = 2'b00;
    mem_to_reg        = 1'b0;
    reg_write_raw     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        // IR load and PC+4 commit only when the fetch actually completes.
        ir_write_raw = bus.mem_ready;
        pc_write_raw = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        alu_src_b = 2'b11;
        reg2loc   = is_stur || is_cbz;
        if (is_r_type) begin
          state_d = S_EXEC_R;
        end else if (is_i_type) begin
          state_d = S_EXEC_I;
        end else if (is_ldur || is_stur) begin
          state_d = S_MEM_ADDR;
        end else if (is_cbz) begin
          state_d = S_BR_CBZ;
        end else if (is_b) begin
          state_d = S_BR_B;
        end else begin
          state_d = S_ILLEGAL;
        end
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = is_ldur ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        state_d       = S_FETCH;
      end

      S_MEM_WR: begin
        // Store data comes from Rt, so keep reg2loc asserted while writing.
        i_or_d        = 1'b1;
        reg2loc       = 1'b1;
        mem_write_raw = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end
      end

      S_BR_CBZ: begin
        reg2loc           = 1'b1;
        alu_src_a         = 1'b1;
        alu_src_b         = 2'b00;
        alu_op            = 2'b01;
        pc_write_cond_raw = 1'b1;
        pc_source         = 2'b01;
        state_d           = S_FETCH;
      end

      S_BR_B: begin
        pc_write_raw = 1'b1;
        pc_source    = 2'b01;
        state_d      = S_FETCH;
      end

      S_ILLEGAL: begin
        state_d = S_ILLEGAL;
      end

      default: begin
        // Unused encodings recover to FETCH.
        state_d = S_FETCH;
      end
    endcase
  end

  // Output drive; write strobes are suppressed in the reset cycle.
  assign bus.ALUOp         = alu_op;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.reg2loc       = reg2loc;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write_raw     & ~rst;
  assign bus.ir_write      = ir_write_raw      & ~rst;
  assign bus.pc_write      = pc_write_raw      & ~rst;
  assign bus.pc_write_cond = pc_write_cond_raw & ~rst;
  assign bus.pc_source     = pc_source;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write_raw     & ~rst;
  assign bus.illegal       = illegal_q;
  assign bus.state         = STATE_W'(state_q);

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Bench for legv8_multicycle_control: directed test-plan scenarios followed by
// randomized instructions with random memory wait states. Expected state
// traces are built per instruction class from the cycle-count rules, and the
// expected control outputs come from a per-state table.
module tb_legv8_multicycle_control;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  legv8_multicycle_control_if #(.STATE_W(4)) bus ();

  legv8_multicycle_control #(.STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction classes
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_CBZ = 4, C_B = 5, C_ILL = 6;

  function automatic int op_class(logic [10:0] op);
    int v;
    v = int'(op);
    if (v == 'h458 || v == 'h658 || v == 'h450 || v == 'h550 || v == 'h69B || v == 'h69A)
      return C_R;
    if ((v >= 'h488 && v <= 'h489) || (v >= 'h688 && v <= 'h689) ||
        (v >= 'h490 && v <= 'h491) || (v >= 'h590 && v <= 'h591))
      return C_I;
    if (v == 'h7C2) return C_LD;
    if (v == 'h7C0) return C_ST;
    if (v >= 'h5A0 && v <= 'h5A7) return C_CBZ;
    if (v >= 'h0A0 && v <= 'h0BF) return C_B;
    return C_ILL;
  endfunction

  // Packed expected controls:
  // {ALUOp, alu_src_a, alu_src_b, reg2loc, i_or_d, mem_read, mem_write,
  //  ir_write, pc_write, pc_write_cond, pc_source, mem_to_reg, reg_write}
  function automatic logic [15:0] model_out(int st, logic rdy, logic [10:0] op, logic in_rst);
    logic [1:0] aluop, srcb, pcs;
    logic srca, r2l, iod, mrd, mwr, irw, pcw, pcwc, m2r, rw;
    int c;
    aluop = 2'b00; srcb = 2'b00; pcs = 2'b00;
    srca = 0; r2l = 0; iod = 0; mrd = 0; mwr = 0; irw = 0;
    pcw = 0; pcwc = 0; m2r = 0; rw = 0;
    c = op_class(op);
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin srcb = 2'b11; r2l = (c == C_ST || c == C_CBZ); end
      2:  begin srca = 1; srcb = 2'b00; aluop = 2'b10; end
      3:  begin srca = 1; srcb = 2'b10; aluop = 2'b10; end
      4:  begin rw = 1; end
      5:  begin srca = 1; srcb = 2'b10; end
      6:  begin mrd = 1; iod = 1; end
      7:  begin rw = 1; m2r = 1; end
      8:  begin iod = 1; r2l = 1; mwr = 1; end
      9:  begin r2l = 1; srca = 1; aluop = 2'b01; pcwc = 1; pcs = 2'b01; end
      10: begin pcw = 1; pcs = 2'b01; end
      default: ;
    endcase
    if (in_rst) begin
      mwr = 0; irw = 0; pcw = 0; pcwc = 0; rw = 0;
    end
    return {aluop, srca, srcb, r2l, iod, mrd, mwr, irw, pcw, pcwc, pcs, m2r, rw};
  endfunction

  function automatic logic [15:0] dut_out();
    return {bus.ALUOp, bus.alu_src_a, bus.alu_src_b, bus.reg2loc, bus.i_or_d,
            bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
            bus.pc_write_cond, bus.pc_source, bus.mem_to_reg, bus.reg_write};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle(int exp_st, logic rdy, logic in_rst);
    check("state", 32'(bus.state), 32'(exp_st));
    check("controls", 32'(dut_out()), 32'(model_out(exp_st, rdy, bus.opcode, in_rst)));
    check("illegal", 32'(bus.illegal), 32'(exp_st == 11));
  endtask

  // One normal cycle: drive on the falling edge, check shortly after.
  task automatic step(int exp_st, logic rdy);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = rdy;
    #1;
    check_cycle(exp_st, rdy, 1'b0);
  endtask

  // One cycle with reset asserted and mem_ready high.
  task automatic reset_step(int exp_st);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check_cycle(exp_st, 1'b1, 1'b1);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one instruction from FETCH to its final state.
  // wf: mem_ready-low cycles in FETCH, wm: in MEM_RD / MEM_WR.
  task automatic run_instr(logic [10:0] op, int wf, int wm, int ill_cycles);
    int c;
    bus.opcode = op;
    c = op_class(op);
    for (int i = 0; i < wf; i++) step(0, 1'b0);
    step(0, 1'b1);
    step(1, rnd_bit());
    case (c)
      C_R:   begin step(2, rnd_bit()); step(4, rnd_bit()); end
      C_I:   begin step(3, rnd_bit()); step(4, rnd_bit()); end
      C_LD:  begin
        step(5, rnd_bit());
        for (int i = 0; i < wm; i++) step(6, 1'b0);
        step(6, 1'b1);
        step(7, rnd_bit());
      end
      C_ST:  begin
        step(5, rnd_bit());
        for (int i = 0; i < wm; i++) step(8, 1'b0);
        step(8, 1'b1);
      end
      C_CBZ: step(9, rnd_bit());
      C_B:   step(10, rnd_bit());
      default: begin
        for (int i = 0; i < ill_cycles; i++) step(11, rnd_bit());
        reset_step(11);
      end
    endcase
  endtask

  function automatic logic [10:0] rand_op(int c);
    logic [10:0] r_ops [6];
    logic [10:0] i_ops [4];
    logic [10:0] op;
    r_ops = '{11'h458, 11'h658, 11'h450, 11'h550, 11'h69B, 11'h69A};
    i_ops = '{11'h488, 11'h688, 11'h490, 11'h590};
    case (c)
      C_R:   op = r_ops[$urandom_range(0, 5)];
      C_I:   op = i_ops[$urandom_range(0, 3)] + 11'($urandom_range(0, 1));
      C_LD:  op = 11'h7C2;
      C_ST:  op = 11'h7C0;
      C_CBZ: op = 11'h5A0 + 11'($urandom_range(0, 7));
      C_B:   op = 11'h0A0 + 11'($urandom_range(0, 31));
      default: begin
        op = 11'($urandom_range(0, 2047));
        for (int k = 0; k < 64 && op_class(op) != C_ILL; k++)
          op = 11'($urandom_range(0, 2047));
        if (op_class(op) != C_ILL) op = 11'h000;
      end
    endcase
    return op;
  endfunction

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = 11'h458;
    @(posedge clk);
    // Reset held: FETCH with mem_ready high must not raise ir_write/pc_write.
    reset_step(0);
    reset_step(0);

    // ADD: 0,1,2,4
    run_instr(11'h458, 0, 0, 0);
    // LDUR with three wait cycles in MEM_RD
    run_instr(11'h7C2, 0, 3, 0);
    // STUR, no waits
    run_instr(11'h7C0, 0, 0, 0);
    // CBZ and B
    run_instr(11'h5A3, 0, 0, 0);
    run_instr(11'h0A5, 0, 0, 0);
    // Illegal opcode: sticky for 10 cycles, then cleared by reset
    run_instr(11'h000, 0, 0, 10);
    // Fetch wait states
    run_instr(11'h488, 2, 0, 0);

    // Reset while in MEM_WR with mem_ready high: the store is abandoned.
    bus.opcode = 11'h7C0;
    step(0, 1'b1);
    step(1, 1'b1);
    step(5, 1'b1);
    reset_step(8);
    step(0, 1'b1);
    step(1, 1'b1);
    step(5, 1'b1);
    step(8, 1'b1);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      int c;
      c = (n % 20 == 19) ? C_ILL : int'($urandom_range(0, 5));
      run_instr(rand_op(c), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 4)));
    end

    // Decoder boundaries just outside the legal ranges
    run_instr(11'h487, 0, 0, 1);
    run_instr(11'h5A8, 0, 0, 1);
    run_instr(11'h0C0, 0, 0, 1);
    run_instr(11'h7C1, 0, 0, 1);
    run_instr(11'h5A7, 0, 0, 0);
    run_instr(11'h0BF, 0, 0, 0);
    run_instr(11'h591, 0, 0, 0);
    step(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/legv8_multicycle_control.md
Name: legv8_multicycle_control

Overview:
- Main control FSM for the multicycle LEGv8 datapath. It is the producer side of the ALUOp interface that the ALU control decoder consumes.
- Sequences each instruction through fetch, decode, execute, memory and writeback states. Generates datapath enables, mux selects and the 2-bit ALUOp from the 11-bit opcode field latched in IR.
- Sits between the instruction register / memory interface and the datapath muxes.

Parameters:
- STATE_W, 4, width of state register and debug state output.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  11  IR[31:21], stable from DECODE onward.
- mem_ready  input  1  memory completes current read/write this cycle.
- ALUOp  output  2  00 add, 01 pass B (CBZ), 10 decode from opcode.
- alu_src_a  output  1  0 PC, 1 register A.
- alu_src_b  output  2  00 register B, 01 constant 4, 10 sign-extended immediate, 11 branch offset <<2.
- reg2loc  output  1  1 selects Rt as read register 2 (STUR, CBZ).
- i_or_d  output  1  0 PC address, 1 ALUOut address.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  load IR.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 reserved.
- mem_to_reg  output  1  1 writeback from MDR.
- reg_write  output  1  register file write.
- illegal  output  1  sticky unsupported-opcode flag.
- state  output  STATE_W  current state, for debug.

Behaviour:
- Reset: state=FETCH, illegal=0. While rst is high, every write strobe (mem_write, ir_write, pc_write, pc_write_cond, reg_write) is forced to 0. Reset mid-instruction abandons that instruction; no partial writes occur after reset is sampled.
- All outputs are Moore-decoded from state, except the mem_ready-gated strobes. Unlisted outputs are 0.
- FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUOp=00, pc_source=00. ir_write and pc_write equal mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=11, ALUOp=00 (precompute branch target into ALUOut), reg2loc=1 if STUR or CBZ. Next state by opcode:
  - ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550, LSL 0x69B, LSR 0x69A -> EXEC_R.
  - ADDI 0x488-0x489, SUBI 0x688-0x689, ANDI 0x490-0x491, ORRI 0x590-0x591 -> EXEC_I.
  - LDUR 0x7C2, STUR 0x7C0 -> MEM_ADDR.
  - CBZ 0x5A0-0x5A7 -> BR_CBZ.
  - B 0x0A0-0x0BF -> BR_B.
  - Anything else -> ILLEGAL.
- EXEC_R (2): alu_src_a=1, alu_src_b=00, ALUOp=10. Next ALU_WB.
- EXEC_I (3): alu_src_a=1, alu_src_b=10, ALUOp=10. Next ALU_WB.
- ALU_WB (4): reg_write=1, mem_to_reg=0. Next FETCH.
- MEM_ADDR (5): alu_src_a=1, alu_src_b=10, ALUOp=00. Next MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD (6): mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
- MEM_WB (7): reg_write=1, mem_to_reg=1. Next FETCH.
- MEM_WR (8): i_or_d=1, reg2loc=1, mem_write=1 held until the mem_ready cycle. Then FETCH.
- BR_CBZ (9): reg2loc=1, alu_src_a=1, alu_src_b=00, ALUOp=01, pc_write_cond=1, pc_source=01. Next FETCH.
- BR_B (10): pc_write=1, pc_source=01. Next FETCH.
- ILLEGAL (11): illegal set, all strobes 0. Stays until rst.
- Unused encodings 12-15 go to FETCH on the next clock.
- Cycle counts with mem_ready tied to 1: R/I type 4, LDUR 5, STUR 4, CBZ/B 3. Each cycle mem_ready is low adds one cycle in FETCH, MEM_RD or MEM_WR.

Test Plan:
- rst high 2 cycles, mem_ready=1, opcode=0x458 -> state sequence 0,1,2,4,0. ALUOp 00,00,10,xx. reg_write=1 only in ALU_WB.
- opcode=0x7C2, mem_ready low 3 cycles in MEM_RD -> state holds 6 for 3 cycles with mem_read=1, i_or_d=1. Then 7 with reg_write=1, mem_to_reg=1. 5+3=8 cycles total.
- opcode=0x7C0, mem_ready=1 -> 0,1,5,8,0. mem_write=1 exactly one cycle. reg_write never asserted.
- opcode=0x5A3 -> BR_CBZ with ALUOp=01, pc_write_cond=1, pc_source=01. opcode=0x0A5 -> BR_B with pc_write=1.
- opcode=0x000 -> ILLEGAL, illegal=1 sticky, no strobes for 10 cycles. rst -> FETCH, illegal=0.
- rst asserted in MEM_WR with mem_ready=1 -> mem_write=0 that cycle, state=FETCH next.
